// File: rtl/lb_reg_bank_wr_ctrl_pkg.sv
// Shared definitions for the register-bank write controller.
//   state_t  : controller FSM encoding (IDLE -> WRITE -> ACK -> IDLE)
//   DEF_*    : default bank geometry
//   idx_w()  : width of a requester index (at least 1 bit)
package lb_reg_bank_wr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam int DEF_NREQ = 2;
    localparam int DEF_NREG = 8;
    localparam int DEF_AW   = 3;
    localparam int DEF_DW   = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lb_rr_arbiter.sv
// Combinational round-robin picker.
//   i_req     : request vector
//   i_rr_ptr  : highest-priority requester for this pick
//   o_win_idx : first set request scanning i_rr_ptr, i_rr_ptr+1, ... mod NREQ
//   o_any_req : at least one request is set
module lb_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_rr_ptr,
    output logic [IW-1:0]   o_win_idx,
    output logic            o_any_req
);

    logic [2*NREQ-1:0] w_dbl;
    int                w_pos;

    // Rotate so that bit 0 is the requester at i_rr_ptr.
    assign w_dbl     = {i_req, i_req} >> i_rr_ptr;
    assign o_any_req = |i_req;

    // Scan downward so the lowest rotated offset is the last one written.
    always_comb begin
        w_pos     = 0;
        o_win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_pos = int'(i_rr_ptr) + k;
                if (w_pos >= NREQ) w_pos = w_pos - NREQ;
                o_win_idx = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/lb_reg_bank_wr_ctrl.sv
// Write controller / arbiter for a bank of NREG x DW registers.
// Requesters share one write path; each transaction runs IDLE -> WRITE -> ACK.
//   clk, reset          : clock, async active-high reset
//   req/req_addr/req_data : per-requester level request, flattened addr/data
//   gnt                 : one-cycle write-complete pulse (one-hot)
//   reg_cs / reg_d      : one-hot register load enable and shared data bus
//   addr_err            : pulses with gnt when the granted address was >= NREG
//   busy                : high in WRITE and ACK
module lb_reg_bank_wr_ctrl
    import lb_reg_bank_wr_ctrl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREG-1:0]   reg_cs,
    output logic [DW-1:0]     reg_d,
    output logic              addr_err,
    output logic              busy
);

    localparam int IW = idx_w(NREQ);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_rr_ptr, w_rr_nxt;
    logic [IW-1:0]   r_win_idx, w_idx_nxt;
    logic [AW-1:0]   r_win_addr, w_addr_nxt;
    logic [DW-1:0]   r_win_data, w_data_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREG-1:0] r_cs, w_cs_nxt;
    logic [DW-1:0]   r_d, w_d_nxt;
    logic            r_err, w_err_nxt;
    logic            r_busy;

    logic [IW-1:0]   w_arb_idx;
    logic            w_any_req;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    lb_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .o_win_idx (w_arb_idx),
        .o_any_req (w_any_req)
    );

    assign w_sel_addr = req_addr[int'(w_arb_idx)*AW +: AW];
    assign w_sel_data = req_data[int'(w_arb_idx)*DW +: DW];

    // Outputs are registered: each is computed for the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_idx_nxt   = r_win_idx;
        w_addr_nxt  = r_win_addr;
        w_data_nxt  = r_win_data;
        w_gnt_nxt   = '0;
        w_cs_nxt    = '0;
        w_d_nxt     = r_d;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_WRITE;
                    w_idx_nxt   = w_arb_idx;
                    w_addr_nxt  = w_sel_addr;
                    w_data_nxt  = w_sel_data;
                    w_d_nxt     = w_sel_data;
                    // Out-of-range addresses still complete, but select nothing.
                    if (32'(w_sel_addr) < 32'(NREG))
                        w_cs_nxt = NREG'(1) << w_sel_addr;
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_ACK;
                w_gnt_nxt   = NREQ'(1) << r_win_idx;
                w_err_nxt   = !(32'(r_win_addr) < 32'(NREG));
                w_rr_nxt    = (r_win_idx == IW'(NREQ - 1)) ? '0 : r_win_idx + IW'(1);
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_win_idx  <= '0;
            r_win_addr <= '0;
            r_win_data <= '0;
            r_gnt      <= '0;
            r_cs       <= '0;
            r_d        <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_win_idx  <= w_idx_nxt;
            r_win_addr <= w_addr_nxt;
            r_win_data <= w_data_nxt;
            r_gnt      <= w_gnt_nxt;
            r_cs       <= w_cs_nxt;
            r_d        <= w_d_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign gnt      = r_gnt;
    assign reg_cs   = r_cs;
    assign reg_d    = r_d;
    assign addr_err = r_err;
    assign busy     = r_busy;

endmodule

// File: tb/tb_lb_reg_bank_wr_ctrl.sv
module tb_lb_reg_bank_wr_ctrl;

    localparam int NREQ = 2;
    localparam int NREG = 6;
    localparam int AW   = 3;
    localparam int DW   = 8;

    localparam int S_CS = 0, S_GNT = 1, S_BUSY = 2, S_ERR = 3, S_D = 4, S_BANK = 5, S_CSQ = 6, S_GQ = 7;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      gnt;
    logic [NREG-1:0]      reg_cs;
    logic [DW-1:0]        reg_d;
    logic                 addr_err;
    logic                 busy;

    typedef struct { logic [NREG-1:0] cs; logic [DW-1:0] d; } cs_ev_t;
    typedef struct { logic [NREQ-1:0] g; logic e; } g_ev_t;
    typedef struct { string name; int sel; int k; int exp; } probe_t;

    cs_ev_t cs_q[$];
    g_ev_t  g_q[$];
    probe_t probe_q[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] bank [NREG];

    lb_reg_bank_wr_ctrl #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .reg_cs   (reg_cs),
        .reg_d    (reg_d),
        .addr_err (addr_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Register bank model: async-reset flops loaded by their chip select.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) if (reg_cs[i]) bank[i] <= reg_d;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops scoreboard entries when the DUT presents cs or gnt.
    always @(negedge clk) begin
        cs_ev_t ce;
        g_ev_t  ge;
        probe_t p;
        int     act;
        chk("cs_onehot", int'($onehot0(reg_cs)), 1);
        chk("cs_gnt_excl", int'((|reg_cs) && (|gnt)), 0);
        if (|reg_cs) begin
            if (cs_q.size() == 0) chk("cs_unexpected", int'(reg_cs), 0);
            else begin
                ce = cs_q.pop_front();
                chk("cs_value", int'(reg_cs), int'(ce.cs));
                chk("cs_data", int'(reg_d), int'(ce.d));
            end
        end
        if ((|gnt) || addr_err) begin
            if (g_q.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
            else begin
                ge = g_q.pop_front();
                chk("gnt_value", int'(gnt), int'(ge.g));
                chk("gnt_addr_err", int'(addr_err), int'(ge.e));
            end
        end
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.sel)
                S_CS:    act = int'(reg_cs);
                S_GNT:   act = int'(gnt);
                S_BUSY:  act = int'(busy);
                S_ERR:   act = int'(addr_err);
                S_D:     act = int'(reg_d);
                S_BANK:  act = int'(bank[p.k]);
                S_CSQ:   act = cs_q.size();
                default: act = g_q.size();
            endcase
            chk(p.name, act, p.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string nm, input int sel, input int k, input int exp);
        probe_q.push_back('{nm, sel, k, exp});
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    task automatic exp_cs(input logic [NREG-1:0] cs, input logic [DW-1:0] d);
        cs_q.push_back('{cs, d});
    endtask

    task automatic exp_gnt(input logic [NREQ-1:0] g, input logic e);
        g_q.push_back('{g, e});
    endtask

    initial begin
        // Reset state
        tick();
        probe("rst_cs", S_CS, 0, 0);
        probe("rst_gnt", S_GNT, 0, 0);
        probe("rst_busy", S_BUSY, 0, 0);
        probe("rst_d", S_D, 0, 0);
        probe("rst_err", S_ERR, 0, 0);
        tick();
        reset = 1'b0;
        tick();

        // Single write: requester 0, addr 3, data A5
        set_req(0, 3'd3, 8'hA5);
        exp_cs(6'h08, 8'hA5);
        exp_gnt(2'b01, 1'b0);
        tick();
        probe("single_cs", S_CS, 0, 'h08);
        probe("single_busy_w", S_BUSY, 0, 1);
        tick();
        probe("single_gnt", S_GNT, 0, 1);
        probe("single_busy_a", S_BUSY, 0, 1);
        probe("single_cs_ack", S_CS, 0, 0);
        req = '0;
        tick();
        probe("single_idle", S_BUSY, 0, 0);
        probe("single_bank3", S_BANK, 3, 'hA5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Simultaneous requests from rr_ptr = 0
        set_req(0, 3'd1, 8'h11);
        set_req(1, 3'd2, 8'h22);
        exp_cs(6'h02, 8'h11);
        exp_cs(6'h04, 8'h22);
        exp_gnt(2'b01, 1'b0);
        exp_gnt(2'b10, 1'b0);
        tick();
        probe("simul_cs0", S_CS, 0, 'h02);
        tick();
        probe("simul_gnt0", S_GNT, 0, 1);
        req[0] = 1'b0;
        tick();
        probe("simul_gap", S_BUSY, 0, 0);
        tick();
        probe("simul_cs1", S_CS, 0, 'h04);
        tick();
        probe("simul_gnt1_3cyc", S_GNT, 0, 2);
        req[1] = 1'b0;
        tick();

        // Fairness: both requesters held high for 6 transactions
        set_req(0, 3'd4, 8'h44);
        set_req(1, 3'd5, 8'h55);
        for (int k = 0; k < 6; k++) begin
            exp_cs((k % 2 == 0) ? 6'h10 : 6'h20, (k % 2 == 0) ? 8'h44 : 8'h55);
            exp_gnt((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        end
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (t == 5)  probe("fair_gnt_t5", S_GNT, 0, 2);
            if (t == 17) probe("fair_gnt_t17", S_GNT, 0, 2);
        end
        req = '0;
        tick();
        tick();
        probe("fair_idle", S_BUSY, 0, 0);
        probe("fair_bank4", S_BANK, 4, 'h44);
        probe("fair_bank5", S_BANK, 5, 'h55);

        // Out-of-range addresses (6 is the first invalid, 7 the last)
        set_req(0, 3'd6, 8'h66);
        exp_gnt(2'b01, 1'b1);
        tick();
        probe("oor6_cs", S_CS, 0, 0);
        probe("oor6_busy", S_BUSY, 0, 1);
        tick();
        probe("oor6_gnt", S_GNT, 0, 1);
        probe("oor6_err", S_ERR, 0, 1);
        req = '0;
        tick();
        probe("oor6_err_clr", S_ERR, 0, 0);
        tick();
        set_req(1, 3'd7, 8'h77);
        exp_gnt(2'b10, 1'b1);
        tick();
        probe("oor7_cs", S_CS, 0, 0);
        tick();
        probe("oor7_err", S_ERR, 0, 1);
        req = '0;
        tick();
        tick();

        // Request withdrawn and inputs changed during WRITE
        set_req(0, 3'd2, 8'h3C);
        exp_cs(6'h04, 8'h3C);
        exp_gnt(2'b01, 1'b0);
        tick();
        req = '0;
        req_data[DW-1:0] = 8'hFF;
        req_addr[AW-1:0] = 3'd5;
        probe("wdraw_d", S_D, 0, 'h3C);
        tick();
        probe("wdraw_gnt", S_GNT, 0, 1);
        probe("wdraw_d_hold", S_D, 0, 'h3C);
        tick();
        tick();
        probe("wdraw_bank2", S_BANK, 2, 'h3C);
        probe("wdraw_bank5", S_BANK, 5, 'h55);

        // Reset mid-write (rr_ptr is 1 beforehand); no posedge while reset is high
        set_req(0, 3'd2, 8'h77);
        exp_cs(6'h04, 8'h77);
        tick();
        @(negedge clk);
        #1;
        reset = 1'b1;
        req = '0;
        probe("abort_cs", S_CS, 0, 0);
        probe("abort_gnt", S_GNT, 0, 0);
        probe("abort_busy", S_BUSY, 0, 0);
        #2;
        reset = 1'b0;
        tick();
        tick();

        // rr_ptr restarted at 0: requester 0 wins first
        set_req(0, 3'd1, 8'h81);
        set_req(1, 3'd0, 8'h90);
        exp_cs(6'h02, 8'h81);
        exp_gnt(2'b01, 1'b0);
        exp_cs(6'h01, 8'h90);
        exp_gnt(2'b10, 1'b0);
        tick();
        tick();
        probe("ptr_rst_gnt0", S_GNT, 0, 1);
        req[0] = 1'b0;
        tick();
        tick();
        tick();
        probe("ptr_rst_gnt1", S_GNT, 0, 2);
        req[1] = 1'b0;
        tick();
        tick();
        probe("cs_queue_empty", S_CSQ, 0, 0);
        probe("gnt_queue_empty", S_GQ, 0, 0);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lb_reg_bank_wr_ctrl.md
Name: lb_reg_bank_wr_ctrl

Overview:
Write controller and arbiter for a bank of NREG DW-bit registers built from single-bit async-reset D flip-flops, each with its own chip select. NREQ requesters (PicoBlaze output-port decoder, UART RX, debug port) share one write path into the bank. The block arbitrates round-robin, latches the winning address and data, and drives one-hot register chip selects and a shared data bus. It acknowledges each write with a one-cycle grant pulse.

Parameters:
NREQ, 2, number of requesters (2..4)
NREG, 8, number of registers in the bank
AW, 3, address width; must satisfy 2**AW >= NREG
DW, 8, register data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  write request per requester; level, held until its gnt
req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
req_data  in  NREQ*DW  flattened write data; requester i at [i*DW +: DW]
gnt  out  NREQ  one-cycle write-complete pulse, one-hot
reg_cs  out  NREG  one-hot register chip select / load enable
reg_d  out  DW  data bus to the register bank
addr_err  out  1  one-cycle pulse; granted write had req_addr >= NREG
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, gnt=0, reg_cs=0, reg_d=0, addr_err=0, busy=0, rr_ptr=0, latched idx/addr/data=0. Taking effect mid-write aborts the write. No cs or gnt is produced from the aborted transaction.
- FSM states are IDLE, WRITE, ACK, with registered outputs.
- IDLE: if any req bit is set, choose winner = first set bit scanning rr_ptr, rr_ptr+1, ... modulo NREQ. Latch win_idx, req_addr and req_data of the winner, then go to WRITE. With no req, stay in IDLE.
- WRITE (exactly 1 cycle): reg_cs[win_addr]=1 if win_addr < NREG, else reg_cs=0. reg_d=win_data. Next state is ACK.
- ACK (exactly 1 cycle): gnt[win_idx]=1. addr_err=1 if win_addr >= NREG. Set rr_ptr = (win_idx+1) mod NREQ. reg_cs=0. Next state is IDLE.
- reg_d holds its last value outside WRITE; it is not cleared.
- Latency and timing: req sampled at edge E0; WRITE during cycle E0..E1; the register bank captures at E1; gnt is high during E1..E2; the FSM is back in IDLE at E2. Throughput is one write per 3 cycles.
- Requester rule: deassert req on the same edge where gnt is sampled high. A req still high in IDLE after its gnt counts as a new write.
- req, addr or data changing or dropping during WRITE/ACK is ignored. The latched write completes.
- Simultaneous requests: one winner per transaction. The others wait and are served in round-robin order. No requester is starved: worst-case wait is (NREQ-1) transactions.
- At most one reg_cs bit and at most one gnt bit are high in any cycle. reg_cs and gnt are never high in the same cycle.
- busy=1 in WRITE and ACK, 0 in IDLE.

Decomposition:
- Shared package/include: FSM state encodings (ST_IDLE=2'd0, ST_WRITE=2'd1, ST_ACK=2'd2), default DW/AW/NREG constants.
- Sub-module lb_rr_arbiter: combinational round-robin pick (req, rr_ptr -> win_idx, any_req). The FSM, latches and output registers stay in the top module.

Test Plan:
- Reset mid-write: assert reset during WRITE with reg_cs=8'h04 -> reg_cs=0, gnt=0, busy=0 immediately. After reset release, no gnt for the aborted write and rr_ptr=0.
- Single write: req=2'b01, addr=3, data=8'hA5 -> reg_cs=8'h08 and reg_d=8'hA5 in cycle 1; gnt=2'b01 in cycle 2; busy=1 for 2 cycles; bank reg3=8'hA5.
- Simultaneous requests: req=2'b11 from reset (rr_ptr=0), req0 addr=1/data=8'h11, req1 addr=2/data=8'h22 -> gnt[0] first, then gnt[1] three cycles later. reg_cs sequence is 8'h02 then 8'h04.
- Fairness: both requesters re-request immediately for 6 transactions -> gnt alternates 01,10,01,10,01,10.
- Out-of-range address: NREG=6, addr=7 -> reg_cs stays 0 throughout; gnt pulses; addr_err=1 in the same cycle as gnt.
- Request withdrawn: req0 drops during WRITE -> write still lands, gnt[0] still pulses. Changing req_data during WRITE does not alter reg_d.
